// File: rtl/csa_pkg.sv
// Shared constant helpers for the carry-save stream accumulator: sizing,
// CSA tree shape, and legality checks for the parameter set.
package csa_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Vector count after l layers of 3:2 reduction starting from n vectors.
    function automatic int csa_layer_cnt(input int n, input int l);
        int c;
        c = n;
        for (int i = 0; i < l; i++) c = 2 * (c / 3) + c % 3;
        return c;
    endfunction

    // Number of 3:2 layers needed to bring n vectors down to a (sum, carry) pair.
    function automatic int csa_depth(input int n);
        int c;
        int d;
        c = n;
        d = 0;
        while (c > 2) begin
            c = 2 * (c / 3) + c % 3;
            d++;
        end
        return d;
    endfunction

    function automatic bit ops_legal(input int n);
        return (n >= 2) && (n <= 8);
    endfunction

    function automatic bit acc_legal(input int acc_w, input int w, input int n);
        return acc_w >= w + clog2(n);
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: three W-bit vectors in, sum and left-shifted carry
// out. The carry out of the top bit is dropped, giving modulo-2^W behaviour.
module csa_3to2 #(
    parameter int W = 24
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    // Majority of the low W-1 bits only; the top majority bit would fall off the shift.
    assign c_o = {(a_i[W-2:0] & b_i[W-2:0]) |
                  (a_i[W-2:0] & c_i[W-2:0]) |
                  (b_i[W-2:0] & c_i[W-2:0]), 1'b0};

endmodule

// File: rtl/csa_stream_accumulator.sv
// Multi-operand packet accumulator. Each beat's operands are folded into a
// carry-save (acc_s, acc_c) pair with no carry propagation; the pair is only
// resolved by a single registered adder once the packet's last beat lands.
// Two result slots (fin, out) let a new packet finish while the previous
// result waits for the consumer.
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_OPS   = 3,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_WIDTH-1:0]       out_sum,
    output logic [CNT_W-1:0]           out_beats
);

    localparam int NVEC  = NUM_OPS + 2;
    localparam int DEPTH = csa_depth(NVEC);

    if (!ops_legal(NUM_OPS)) begin : g_bad_ops
        $error("csa_stream_accumulator: NUM_OPS must be in 2..8");
    end
    if (!acc_legal(ACC_WIDTH, WIDTH, NUM_OPS)) begin : g_bad_acc
        $error("csa_stream_accumulator: ACC_WIDTH too narrow for WIDTH and NUM_OPS");
    end

    logic [ACC_WIDTH-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d;
    logic [ACC_WIDTH-1:0] fin_s_q, fin_s_d, fin_c_q, fin_c_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, fin_cnt_q, fin_cnt_d, out_beats_q, out_beats_d;
    logic                 fin_valid_q, fin_valid_d, out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] t_s, t_c;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 accept, out_adv;

    // Reduction tree: level 0 holds zero-extended operands plus the running
    // pair; each later level is the 3:2 reduction of the one before, with
    // leftover vectors passed straight through.
    for (genvar l = 0; l <= DEPTH; l++) begin : g_lvl
        localparam int N = csa_layer_cnt(NVEC, l);
        logic [ACC_WIDTH-1:0] v [N];
        if (l == 0) begin : g_in
            for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
                assign v[k] = {{(ACC_WIDTH-WIDTH){1'b0}}, in_ops[k*WIDTH +: WIDTH]};
            end
            assign v[NUM_OPS]   = acc_s_q;
            assign v[NUM_OPS+1] = acc_c_q;
        end else begin : g_red
            localparam int NP = csa_layer_cnt(NVEC, l-1);
            localparam int NG = NP / 3;
            for (genvar g = 0; g < NG; g++) begin : g_csa
                csa_3to2 #(.W(ACC_WIDTH)) u_csa (
                    .a_i (g_lvl[l-1].v[3*g]),
                    .b_i (g_lvl[l-1].v[3*g+1]),
                    .c_i (g_lvl[l-1].v[3*g+2]),
                    .s_o (v[2*g]),
                    .c_o (v[2*g+1])
                );
            end
            for (genvar r = 0; r < NP % 3; r++) begin : g_pass
                assign v[2*NG+r] = g_lvl[l-1].v[3*NG+r];
            end
        end
    end

    assign t_s = g_lvl[DEPTH].v[0];
    assign t_c = g_lvl[DEPTH].v[1];

    // Input may move whenever the fin slot is empty or will drain this edge.
    assign in_ready = !fin_valid_q || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_adv  = fin_valid_q && (!out_valid_q || out_ready);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // Next-state for accumulator, fin slot and output slot.
    always_comb begin
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        cnt_d       = cnt_q;
        fin_s_d     = fin_s_q;
        fin_c_d     = fin_c_q;
        fin_cnt_d   = fin_cnt_q;
        fin_valid_d = fin_valid_q;
        out_sum_d   = out_sum_q;
        out_beats_d = out_beats_q;
        out_valid_d = out_valid_q;

        if (out_adv) begin
            out_sum_d   = fin_s_q + fin_c_q;
            out_beats_d = fin_cnt_q;
            out_valid_d = 1'b1;
            fin_valid_d = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                fin_s_d     = t_s;
                fin_c_d     = t_c;
                fin_cnt_d   = cnt_inc;
                fin_valid_d = 1'b1;
                acc_s_d     = '0;
                acc_c_d     = '0;
                cnt_d       = '0;
            end else begin
                acc_s_d = t_s;
                acc_c_d = t_c;
                cnt_d   = cnt_inc;
            end
        end
    end

    // State registers; reset drops any partial packet and pending results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            cnt_q       <= '0;
            fin_s_q     <= '0;
            fin_c_q     <= '0;
            fin_cnt_q   <= '0;
            fin_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_beats_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            cnt_q       <= cnt_d;
            fin_s_q     <= fin_s_d;
            fin_c_q     <= fin_c_d;
            fin_cnt_q   <= fin_cnt_d;
            fin_valid_q <= fin_valid_d;
            out_sum_q   <= out_sum_d;
            out_beats_q <= out_beats_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_beats = out_beats_q;

endmodule
